booth_product_accumulator: RTL and testbench
============================================

Name: booth_product_accumulator

Overview:
- Sequential stage directly downstream of booth_multiplier_9_CLA.
- Consumes its signed 18-bit products as a valid/ready stream and accumulates a group of terms into a saturating signed accumulator.
- Emits one result per group, with term count and an overflow flag.
- Turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- PROD_WIDTH, 18, width of the signed product input; matches the multiplier's S (2*width, width=9).
- ACC_WIDTH, 24, width of the signed accumulator and result; must be >= PROD_WIDTH.
- MAX_TERMS, 16, maximum terms per group; the group is force-closed at this count.
- CNT_WIDTH, 5, width of the term counter; must hold MAX_TERMS, i.e. $clog2(MAX_TERMS+1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort: discards the current group or pending result
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_prod  input  PROD_WIDTH  signed product (two's complement)
- in_last  input  1  beat is the final term of the group
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_acc  output  ACC_WIDTH  signed accumulated result
- out_count  output  CNT_WIDTH  number of terms in the result
- out_ovf  output  1  saturation occurred at least once in this group

Behaviour:
- States: IDLE (acc=0, count=0), ACCUM (count>=1, group open), DONE (result held).
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - out_acc=0, out_count=0, out_ovf=0, out_valid=0.
  - in_ready=1 once rst_n deasserts.
- in_ready = (state != DONE). It is combinational from state only, never from in_valid.
- A beat is accepted when in_valid && in_ready at a rising edge.
- Per accepted beat:
  - sum = acc + sign_extend(in_prod), computed at ACC_WIDTH+1 bits.
  - If sum > 2^(ACC_WIDTH-1)-1, acc takes the max positive value; if sum < -2^(ACC_WIDTH-1), acc takes the min negative value; either case sets ovf (sticky for the group).
  - Otherwise acc takes sum.
  - count increments.
  - Later beats accumulate from the saturated value.
- Transitions:
  - IDLE -> ACCUM on an accepted beat with in_last=0 and count+1 < MAX_TERMS.
  - IDLE or ACCUM -> DONE on an accepted beat with in_last=1 or count+1 == MAX_TERMS.
  - DONE -> IDLE when out_valid && out_ready. On that edge acc, count and ovf clear to 0.
- Latency: the closing beat accepted at edge k gives out_valid=1 and final out_acc/out_count/out_ovf visible after edge k. There is no combinational path from in_* to out_*.
- out_valid = (state == DONE).
- In DONE, out_acc/out_count/out_ovf stay stable until the handshake. Beats arriving while in_ready=0 are ignored.
- out_acc/out_count/out_ovf always show the live registers. Consumers read them only while out_valid=1.
- Handshake edge: in_ready rises the cycle after the out handshake. A DONE -> IDLE edge never also accepts a beat.
- Priority: rst_n > clear > normal operation.
- clear=1 at an edge, in any state:
  - State goes to IDLE; acc, count, ovf clear; out_valid drops.
  - A beat presented in the same cycle is dropped, not accumulated.
- in_last on the MAX_TERMS-th beat closes the group exactly once; no extra state.
- Asynchronous reset mid-group discards all partial state.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> outputs 0 immediately; after release in_ready=1, out_valid=0.
- Basic group: beats 65536, -65280, 7 (last on 3rd), out_ready=1 -> out_valid for 1 cycle with out_acc=263, out_count=3, out_ovf=0; next cycle in_ready=1, out_acc=0.
- Saturation (ACC_WIDTH=18 override): beats 65536, 65536 (last), then -5 in a new group with last -> first result out_acc=131071, out_ovf=1, out_count=2; second result out_acc=-5, out_ovf=0.
- Forced close: 16 beats of value 1, in_last never set -> out_valid after 16th beat, out_acc=16, out_count=16, in_ready=0; a 17th beat is held off until the handshake.
- Backpressure: result pending with out_ready=0 for 5 cycles while in_valid=1 with beat 99 -> out_valid/out_acc stable, in_ready=0, 99 not accumulated; after out_ready=1 handshake, 99 is accepted next cycle as term 1 of a new group.
- Abort: 2 beats (10, 20), then clear=1 with in_valid=1 (beat 5) -> out_acc=0, count=0, state IDLE, 5 dropped. Repeat with rst_n pulse instead of clear -> same state.

Source files
------------

// File: rtl/booth_product_accumulator.sv
`default_nettype none
// ============================================================================
// booth_product_accumulator
// Saturating signed accumulator that folds a group of multiplier products into
// one result, delivered over valid/ready with term count and overflow flag.
// Revision: 1.0
// ============================================================================
module booth_product_accumulator #(
   parameter int PROD_WIDTH = 18,
   parameter int ACC_WIDTH  = 24,
   parameter int MAX_TERMS  = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PROD_WIDTH-1:0] in_prod,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_acc,
   output logic [CNT_WIDTH-1:0]  out_count,
   output logic                  out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TERMS);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic                   ovf_q, ovf_d;

   logic [ACC_WIDTH:0]     sum;
   logic [CNT_WIDTH-1:0]   count_inc;
   logic                   accept;
   logic                   close_grp;

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign out_acc   = acc_q;
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

   assign accept    = in_valid & in_ready;
   // One guard bit above the accumulator exposes signed overflow of the add.
   assign sum       = {acc_q[ACC_WIDTH-1], acc_q}
                    + {{(ACC_WIDTH+1-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
   assign count_inc = count_q + CNT_WIDTH'(1);
   assign close_grp = in_last | (count_inc == MAX_CNT);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  count_d = count_inc;
                  if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                     acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                     ovf_d = 1'b1;
                  end else begin
                     acc_d = sum[ACC_WIDTH-1:0];
                  end
                  state_d = close_grp ? DONE : ACCUM;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  count_d = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_booth_product_accumulator.sv
`default_nettype none
// ============================================================================
// tb_booth_product_accumulator
// Bench for booth_product_accumulator at ACC_WIDTH 24 and 18 in lockstep.
// Revision: 1.0
// ============================================================================
module tb_booth_product_accumulator;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic [17:0] in_prod;
   logic        in_last;
   logic        out_ready;

   logic        in_ready,  in_ready_s;
   logic        out_valid, out_valid_s;
   logic [23:0] out_acc;
   logic [17:0] out_acc_s;
   logic [4:0]  out_count, out_count_s;
   logic        out_ovf,   out_ovf_s;

   int total = 0;
   int bad   = 0;

   // Reference state: the terms of the open/pending group and whether a result waits.
   bit     m_pending;
   longint m_terms[$];

   booth_product_accumulator dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
   );

   booth_product_accumulator #(.ACC_WIDTH(18)) dut_s (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_acc(out_acc_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint sat_sum(input int w, output bit ovf);
      longint a, hi, lo;
      a   = 0;
      hi  = (64'sd1 <<< (w - 1)) - 1;
      lo  = -(64'sd1 <<< (w - 1));
      ovf = 1'b0;
      foreach (m_terms[i]) begin
         a += m_terms[i];
         if (a > hi) begin a = hi; ovf = 1'b1; end
         else if (a < lo) begin a = lo; ovf = 1'b1; end
      end
      return a;
   endfunction

   task automatic check_all();
      longint      e24, e18;
      bit          o24, o18;
      logic [23:0] x24;
      logic [17:0] x18;
      e24 = sat_sum(24, o24);
      e18 = sat_sum(18, o18);
      x24 = e24[23:0];
      x18 = e18[17:0];
      chk("in_ready",    in_ready,    !m_pending);
      chk("out_valid",   out_valid,   m_pending);
      chk("out_acc",     out_acc,     x24);
      chk("out_count",   out_count,   m_terms.size());
      chk("out_ovf",     out_ovf,     o24);
      chk("in_ready_s",  in_ready_s,  !m_pending);
      chk("out_valid_s", out_valid_s, m_pending);
      chk("out_acc_s",   out_acc_s,   x18);
      chk("out_count_s", out_count_s, m_terms.size());
      chk("out_ovf_s",   out_ovf_s,   o18);
   endtask

   // One clock of stimulus; the model advances on the same edge, outputs checked 1 ns later.
   task automatic step(input bit v, input int p, input bit l, input bit ordy, input bit clr);
      logic signed [17:0] pv;
      @(negedge clk);
      pv        = p[17:0];
      in_valid  = v;
      in_prod   = pv;
      in_last   = l;
      out_ready = ordy;
      clear     = clr;
      @(posedge clk);
      if (clr) begin
         m_pending = 1'b0;
         m_terms.delete();
      end else if (m_pending) begin
         if (ordy) begin
            m_pending = 1'b0;
            m_terms.delete();
         end
      end else if (v) begin
         m_terms.push_back(longint'(pv));
         if (l || m_terms.size() == 16) m_pending = 1'b1;
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      m_pending = 1'b0;
      m_terms.delete();
      chk("rst_acc_now",   out_acc,   24'd0);
      chk("rst_valid_now", out_valid, 1'b0);
      check_all();
      in_valid = 1'b0; clear = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready_after", in_ready, 1'b1);
      check_all();
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = '0;
      in_last = 1'b0; out_ready = 1'b0;
      m_pending = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // Basic group
      step(1, 65536, 0, 1, 0);
      step(1, -65280, 0, 1, 0);
      step(1, 7, 1, 1, 0);
      chk("basic_valid", out_valid, 1'b1);
      chk("basic_acc",   out_acc,   24'd263);
      chk("basic_count", out_count, 5'd3);
      chk("basic_ovf",   out_ovf,   1'b0);
      step(0, 0, 0, 1, 0);
      chk("basic_valid_drop", out_valid, 1'b0);
      chk("basic_ready_back", in_ready,  1'b1);
      chk("basic_acc_clr",    out_acc,   24'd0);

      // Saturation on the 18-bit instance
      step(1, 65536, 0, 0, 0);
      step(1, 65536, 1, 0, 0);
      chk("sat_acc_s",   out_acc_s,   18'h1FFFF);
      chk("sat_ovf_s",   out_ovf_s,   1'b1);
      chk("sat_count_s", out_count_s, 5'd2);
      chk("sat_acc_wide", out_acc,    24'd131072);
      step(0, 0, 0, 1, 0);
      step(1, -5, 1, 0, 0);
      chk("sat_neg_s",  out_acc_s, 18'h3FFFB);
      chk("sat_clr_ovf", out_ovf_s, 1'b0);
      step(0, 0, 0, 1, 0);

      // Forced close after 16 terms
      for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0);
      chk("force_valid", out_valid, 1'b1);
      chk("force_acc",   out_acc,   24'd16);
      chk("force_count", out_count, 5'd16);
      chk("force_ready", in_ready,  1'b0);
      step(1, 1, 0, 0, 0);
      chk("force_hold", out_count, 5'd16);
      step(1, 1, 0, 1, 0);
      chk("force_noacc", out_count, 5'd0);
      step(1, 1, 1, 0, 0);
      chk("force_next", out_count, 5'd1);
      step(0, 0, 0, 1, 0);

      // Backpressure
      step(1, 3, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 99, 0, 0, 0);
         chk("bp_acc",   out_acc,  24'd3);
         chk("bp_ready", in_ready, 1'b0);
      end
      step(1, 99, 0, 1, 0);
      step(1, 99, 0, 0, 0);
      chk("bp_new_acc",   out_acc,   24'd99);
      chk("bp_new_count", out_count, 5'd1);
      step(0, 0, 0, 0, 1);

      // Abort by clear, then by reset
      step(1, 10, 0, 0, 0);
      step(1, 20, 0, 0, 0);
      step(1, 5, 0, 0, 1);
      chk("clr_acc",   out_acc,   24'd0);
      chk("clr_count", out_count, 5'd0);
      chk("clr_ready", in_ready,  1'b1);
      step(1, 10, 0, 0, 0);
      step(1, 20, 0, 0, 0);
      do_reset();
      chk("rst_count", out_count, 5'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int p;
         if ($urandom_range(400) == 0) begin
            do_reset();
         end else begin
            p = ($urandom_range(1) == 1) ? int'($urandom) : int'($urandom_range(2000)) - 1000;
            step($urandom_range(3) != 0, p, $urandom_range(4) == 0,
                 $urandom_range(1) == 1, $urandom_range(40) == 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
